// File: rtl/srt4_otf_conv.sv
// Radix-4 SRT on-the-fly quotient converter: keeps Q and QM = Q - 1 ulp, then applies the final remainder-sign correction.
// Optional illegal-digit flag enabled by defining SRT4_OTF_ERR_EN.
module srt4_otf_conv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic [1:0]       q,
  input  logic             neg,
  input  logic             rem_valid,
  input  logic             rem_neg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic             err
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIX} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_acc, qm_acc;
  logic [WIDTH-1:0] q_next, qm_next;
  logic [CW-1:0]    cnt;
  logic [1:0]       mag;
  logic             accept;
  logic             is_pos;
  logic             is_nonneg;
  logic             last_dig;

`ifdef SRT4_OTF_ERR_EN
  logic illegal;
  assign illegal = (q == 2'b11);
  assign mag     = illegal ? 2'b00 : q;
`else
  // Without the error check, the code 11 collapses onto magnitude 2.
  assign mag = q[1] ? 2'b10 : {1'b0, q[0]};
`endif

  assign accept    = dig_valid && dig_ready;
  assign is_pos    = !neg && (mag != 2'b00);
  assign is_nonneg = !neg || (mag == 2'b00);
  assign last_dig  = (cnt == CW'(NDIG - 1));

  // Appended fields are always 0..3, so each update is a shift plus concatenation.
  assign q_next  = is_nonneg ? {q_acc[WIDTH-3:0], mag}
                             : {qm_acc[WIDTH-3:0], 2'(3'd4 - {1'b0, mag})};
  assign qm_next = is_pos    ? {q_acc[WIDTH-3:0], 2'(mag - 2'd1)}
                             : {qm_acc[WIDTH-3:0], 2'(2'd3 - mag)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_acc  <= '0;
      qm_acc <= '1;
      cnt    <= '0;
      quot   <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FIX) && rem_valid;
      case (state)
        IDLE: if (start) begin
          q_acc  <= '0;
          qm_acc <= '1;
          cnt    <= '0;
        end
        CONV: if (accept) begin
          q_acc  <= q_next;
          qm_acc <= qm_next;
          cnt    <= cnt + CW'(1);
        end
        FIX: if (rem_valid) quot <= rem_neg ? qm_acc : q_acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (accept && last_dig) state_next = FIX;
      FIX:     if (rem_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dig_ready = (state == CONV);
    busy      = (state == CONV) || (state == FIX);
  end

`ifdef SRT4_OTF_ERR_EN
  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (state == IDLE && start)
      err <= 1'b0;
    else if (accept && illegal)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srt4_otf_conv.sv
// Scoreboard bench for srt4_otf_conv: expected quotients are queued per conversion and checked when done pulses.
// Expectations for the q = 11 case follow SRT4_OTF_ERR_EN.
module tb_srt4_otf_conv;

  localparam int WIDTH = 8;

  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] NZ = 3'b100;
  localparam logic [2:0] N1 = 3'b101;
  localparam logic [2:0] N2 = 3'b110;
  localparam logic [2:0] PI = 3'b011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             dig_valid = 1'b0;
  logic             dig_ready;
  logic [1:0]       q = 2'b00;
  logic             neg = 1'b0;
  logic             rem_valid = 1'b0;
  logic             rem_neg = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic             err;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [WIDTH-1:0] quot;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  srt4_otf_conv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .q(q), .neg(neg), .rem_valid(rem_valid), .rem_neg(rem_neg),
    .busy(busy), .done(done), .quot(quot), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; called right after an edge, so a start here may land in a done cycle.
  task automatic applyStimulus(input logic [3:0][2:0] digs, input bit stall, input int rem_delay,
                               input logic rneg, input logic [WIDTH-1:0] exp_quot, input logic exp_err);
    exp_t e;
    e.quot = exp_quot;
    e.err  = exp_err;
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dig_valid = 1'b1;
      neg = digs[i][2];
      q   = digs[i][1:0];
      tick();
      if (stall && i < 3) begin
        dig_valid = 1'b0;
        q = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    dig_valid = 1'b0;
    q = 2'b00;
    neg = 1'b0;
    for (int i = 0; i < rem_delay; i++) tick();
    checkOutput("busy_in_fix", 32'(busy), 32'd1);
    rem_valid = 1'b1;
    rem_neg = rneg;
    tick();
    rem_valid = 1'b0;
    rem_neg = 1'b0;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_on_done", 32'(busy), 32'd0);
  endtask

  // Monitor: every done pulse pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("quot", 32'(quot), 32'(e.quot));
          checkOutput("err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] ill_quot;
    logic             ill_err;
`ifdef SRT4_OTF_ERR_EN
    ill_quot = 8'h51;
    ill_err  = 1'b1;
`else
    ill_quot = 8'h59;
    ill_err  = 1'b0;
`endif
    repeat (2) tick();
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(dig_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quot", 32'(quot), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    tick();

    applyStimulus({P1, Z, P2, P1}, 1'b0, 0, 1'b0, 8'h61, 1'b0);
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    applyStimulus({N2, P1, N1, P2}, 1'b0, 0, 1'b1, 8'h71, 1'b0);
    applyStimulus({N2, P1, N1, P2}, 1'b0, 0, 1'b0, 8'h72, 1'b0);
    applyStimulus({Z, Z, Z, N1}, 1'b0, 0, 1'b0, 8'hC0, 1'b0);
    applyStimulus({NZ, NZ, NZ, NZ}, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    applyStimulus({P1, Z, P2, P1}, 1'b1, 5, 1'b0, 8'h61, 1'b0);
    applyStimulus({P1, PI, P1, P1}, 1'b0, 0, 1'b0, ill_quot, ill_err);
    applyStimulus({N2, P1, N1, P2}, 1'b0, 1, 1'b1, 8'h71, 1'b0);

    // Abort mid-conversion with reset after the second digit.
    start = 1'b1;
    tick();
    start = 1'b0;
    dig_valid = 1'b1;
    q = 2'b01;
    tick();
    tick();
    dig_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(dig_ready), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quot", 32'(quot), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    applyStimulus({N2, P1, N1, P2}, 1'b0, 0, 1'b0, 8'h72, 1'b0);

    repeat (3) tick();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/srt4_otf_conv.md
Name: srt4_otf_conv

Overview:
- Back end of the radix-4 SRT divider: consumes the signed quotient digits produced each iteration by the quotient-select logic (2-bit magnitude plus sign) and converts them on the fly to a plain binary quotient.
- Keeps the two running registers Q and QM (QM = Q − 1 ulp), so no carry-propagate add is needed per digit.
- When the last digit arrives, the block applies the final negative-remainder correction and presents the result to the divider top level.

Parameters:
- WIDTH, 8, quotient width in bits. Must be even and ≥ 4.
- NDIG (localparam), WIDTH/2, number of radix-4 digits per division.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a conversion. Accepted only in IDLE.
- dig_valid  input  1  a digit is presented on q/neg.
- dig_ready  output  1  high in CONV. A digit is consumed when dig_valid && dig_ready.
- q  input  2  digit magnitude: 00 = 0, 01 = 1, 10 = 2, 11 = illegal.
- neg  input  1  digit sign, 1 = negative. neg with q = 00 means digit 0.
- rem_valid  input  1  final remainder sign is presented on rem_neg.
- rem_neg  input  1  1 = final partial remainder is negative, so the quotient must be corrected by −1.
- busy  output  1  high in CONV or FIX.
- done  output  1  one-cycle pulse when quot becomes valid.
- quot  output  WIDTH  converted quotient. Held until the next accepted start.
- err  output  1  illegal-digit flag (see Optional Feature).

Behaviour:
- Reset values: state = IDLE, Q = 0, QM = all ones, cnt = 0, quot = 0, done = 0, busy = 0, dig_ready = 0, err = 0.
- Reset has priority over every other input, in any state, including mid-conversion. The partial result is discarded.
- States:
  - IDLE: start = 1 → CONV. On the same edge load Q = 0, QM = {WIDTH{1}}, cnt = 0, err = 0.
  - CONV: dig_ready = 1. Each accepted digit d updates Q/QM and increments cnt. On the edge that accepts the NDIG-th digit → FIX. Cycles with dig_valid = 0 are stalls: no update.
  - FIX: dig_ready = 0. On the edge where rem_valid = 1: quot = rem_neg ? QM : Q, done = 1 next cycle, → IDLE. Without rem_valid, wait indefinitely.
- Digit update, with d in {−2 … +2} and all arithmetic mod 2^WIDTH (left shift drops MSBs):
  - Q' = (d ≥ 0) ? 4Q + d : 4QM + (4 + d)
  - QM' = (d > 0) ? 4Q + (d − 1) : 4QM + (3 + d)
- Both appended 2-bit fields are always in 0..3, so no borrow propagates.
- Latency: done rises in the cycle after rem_valid is accepted. Minimum start-to-done is NDIG + 2 cycles.
- start is ignored outside IDLE. start in the same cycle that done is high is accepted, because the state is already IDLE.
- rem_valid is ignored outside FIX. dig_valid is ignored outside CONV.
- done is high for exactly one cycle per conversion.
- busy = (state == CONV) || (state == FIX).

Optional Feature:
- Macro: SRT4_OTF_ERR_EN.
- Defined:
  - An accepted digit with q = 11 sets err.
  - err is sticky until the next accepted start or rst.
  - The illegal digit is converted as 0.
- Not defined:
  - err is tied to 0.
  - q = 11 decodes by q[1] only, i.e. as magnitude 2.
  - No extra flops are added.

Test Plan:
- WIDTH = 8. start; digits +1, +2, 0, +1 back-to-back; rem_valid with rem_neg = 0 → done pulse, quot = 0x61, busy low the cycle after done.
- Digits +2, −1, +1, −2 with rem_neg = 1 → quot = 0x71 (0x72 − 1). Rerun with rem_neg = 0 → quot = 0x72.
- Digits −1, 0, 0, 0 (neg = 1, q = 00 on the zeros) with rem_neg = 0 → quot = 0xC0 (mod-256 wrap). Separately, all digits neg = 1, q = 00 → quot = 0x00.
- Stalls: dig_valid toggled 1/0 between digits, rem_valid delayed 5 cycles → same quot as the back-to-back run. start pulsed while busy → ignored. start on the done cycle → new conversion begins.
- Assert rst after the 2nd digit → IDLE next cycle, all outputs at reset values. A following full conversion is correct.
- With SRT4_OTF_ERR_EN: third digit q = 11 → err = 1 after accept, quot computed with that digit = 0. err clears on the next start. Without the macro: err stays 0 and q = 11 behaves as +2 or −2.
